// File: rtl/mcpu_ctrl_pkg.sv
// rtl/mcpu_ctrl_pkg.sv - state, opcode, funct and ALU encodings for the multicycle control unit
package mcpu_ctrl_pkg;

  localparam int ST_W_DEF = 5;

  typedef enum logic [4:0] {
    S_INIT = 5'd0,  S_IF   = 5'd1,  S_ID   = 5'd2,  S_EX_R = 5'd3,
    S_WB_R = 5'd4,  S_EX_I = 5'd5,  S_WB_I = 5'd6,  S_MA   = 5'd7,
    S_MR   = 5'd8,  S_WB_L = 5'd9,  S_MW   = 5'd10, S_BEQ  = 5'd11,
    S_BNE  = 5'd12, S_J    = 5'd13, S_JAL  = 5'd14, S_JR   = 5'd15,
    S_LUI  = 5'd16
  } state_t;

  typedef enum logic [3:0] {
    C_ILL = 4'd0, C_R  = 4'd1, C_JR  = 4'd2, C_LW = 4'd3, C_SW  = 4'd4, C_BEQ = 4'd5,
    C_BNE = 4'd6, C_I  = 4'd7, C_LUI = 4'd8, C_J  = 4'd9, C_JAL = 4'd10
  } cls_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_JR  = 6'b001000;
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_XOR = 6'b100110;
  localparam logic [5:0] FN_NOR = 6'b100111;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_XOR = 3'b011;
  localparam logic [2:0] ALU_NOR = 3'b100;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef struct packed {
    logic       pc_write;
    logic       pcwritecond;
    logic       branch;
    logic       iord;
    logic       alu_src_a;
    logic       regwrite;
    logic       mem_w;
    logic [1:0] pc_source;
    logic [1:0] alu_src_b;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic [2:0] alu_ops;
  } ctrl_t;

  // Moore control word for a state; ovf gates the R/I write-back enable.
  function automatic ctrl_t ctrl_for(state_t s, logic ovf, logic [2:0] alu);
    ctrl_t c;
    c = '0;
    c.alu_ops = ALU_ADD;
    case (s)
      S_IF:   begin c.pc_write = 1'b1; c.alu_src_b = 2'b01; end
      S_ID:   c.alu_src_b = 2'b11;
      S_EX_R: begin c.alu_src_a = 1'b1; c.alu_ops = alu; end
      S_WB_R: begin c.reg_dst = 2'b01; c.regwrite = ~ovf; end
      S_EX_I: begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; c.alu_ops = alu; end
      S_WB_I: c.regwrite = ~ovf;
      S_MA:   begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
      S_MR:   c.iord = 1'b1;
      S_WB_L: begin c.mem_to_reg = 2'b01; c.regwrite = 1'b1; end
      S_MW:   begin c.iord = 1'b1; c.mem_w = 1'b1; end
      S_BEQ, S_BNE: begin
        c.alu_src_a   = 1'b1;
        c.alu_ops     = ALU_SUB;
        c.pcwritecond = 1'b1;
        c.pc_source   = 2'b01;
        c.branch      = (s == S_BEQ);
      end
      S_J:    begin c.pc_source = 2'b10; c.pc_write = 1'b1; end
      S_JAL:  begin
        c.pc_source  = 2'b10;
        c.pc_write   = 1'b1;
        c.reg_dst    = 2'b10;
        c.mem_to_reg = 2'b11;
        c.regwrite   = 1'b1;
      end
      S_JR:   begin c.alu_src_a = 1'b1; c.pc_write = 1'b1; end
      S_LUI:  begin c.mem_to_reg = 2'b10; c.regwrite = 1'b1; end
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mcpu_ctrl_dec.sv
// rtl/mcpu_ctrl_dec.sv - opcode/funct to instruction class, ALU code and overflow-check flag
module mcpu_ctrl_dec
  import mcpu_ctrl_pkg::*;
(
  input  logic [31:0] inst,
  output logic [3:0]  cls,
  output logic [2:0]  alu_op,
  output logic        ovf_chk
);

  logic [5:0] op;
  logic [5:0] fn;
  logic       unused_fields;

  assign op = inst[31:26];
  assign fn = inst[5:0];
  assign unused_fields = ^inst[25:6];

  always_comb begin
    cls     = C_ILL;
    alu_op  = ALU_ADD;
    ovf_chk = 1'b0;
    case (op)
      OP_RTYPE: begin
        case (fn)
          FN_ADD: begin cls = C_R; ovf_chk = 1'b1; end
          FN_SUB: begin cls = C_R; alu_op = ALU_SUB; ovf_chk = 1'b1; end
          FN_AND: begin cls = C_R; alu_op = ALU_AND; end
          FN_OR:  begin cls = C_R; alu_op = ALU_OR;  end
          FN_XOR: begin cls = C_R; alu_op = ALU_XOR; end
          FN_NOR: begin cls = C_R; alu_op = ALU_NOR; end
          FN_SLT: begin cls = C_R; alu_op = ALU_SLT; end
          FN_JR:  cls = C_JR;
          default: ;
        endcase
      end
      OP_LW:   cls = C_LW;
      OP_SW:   cls = C_SW;
      OP_BEQ:  cls = C_BEQ;
      OP_BNE:  cls = C_BNE;
      OP_ADDI: begin cls = C_I; ovf_chk = 1'b1; end
      OP_ANDI: begin cls = C_I; alu_op = ALU_AND; end
      OP_ORI:  begin cls = C_I; alu_op = ALU_OR;  end
      OP_SLTI: begin cls = C_I; alu_op = ALU_SLT; end
      OP_LUI:  cls = C_LUI;
      OP_J:    cls = C_J;
      OP_JAL:  cls = C_JAL;
      default: ;
    endcase
  end

endmodule

// File: rtl/mcpu_ctrl.sv
// rtl/mcpu_ctrl.sv - multicycle MIPS control FSM driving datapath selects and write enables
module mcpu_ctrl
  import mcpu_ctrl_pkg::*;
#(
  parameter int ST_W = ST_W_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [31:0]     inst,
  input  logic            zero,
  input  logic            overflow,
  input  logic            MIO_ready,
  output logic            pc_write,
  output logic            pcwritecond,
  output logic            branch,
  output logic            IorD,
  output logic            AluSrcA,
  output logic            regwrite,
  output logic            IRwrite,
  output logic            mem_w,
  output logic [1:0]      PCSource,
  output logic [1:0]      ALUSrcB,
  output logic [1:0]      RegDst,
  output logic [1:0]      MemToReg,
  output logic [2:0]      ALU_ops,
  output logic            illegal_inst,
  output logic [ST_W-1:0] state
);

  state_t     cur;
  state_t     nxt;
  logic       ovf_flag;
  logic       ovf_nxt;
  ctrl_t      ctrl;
  logic [3:0] cls;
  logic [2:0] dec_alu;
  logic       ovf_chk;
  logic       unused_zero;

  // zero is consumed by the datapath's branch gate, not by the sequencer
  assign unused_zero = zero;

  mcpu_ctrl_dec u_dec (
    .inst    (inst),
    .cls     (cls),
    .alu_op  (dec_alu),
    .ovf_chk (ovf_chk)
  );

  always_comb begin
    nxt     = S_IF;
    ovf_nxt = ovf_flag;
    case (cur)
      S_IF: nxt = MIO_ready ? S_ID : S_IF;
      S_ID: begin
        case (cls)
          C_R:     nxt = S_EX_R;
          C_JR:    nxt = S_JR;
          C_LW,
          C_SW:    nxt = S_MA;
          C_BEQ:   nxt = S_BEQ;
          C_BNE:   nxt = S_BNE;
          C_I:     nxt = S_EX_I;
          C_LUI:   nxt = S_LUI;
          C_J:     nxt = S_J;
          C_JAL:   nxt = S_JAL;
          default: nxt = S_IF;
        endcase
      end
      S_EX_R: begin nxt = S_WB_R; ovf_nxt = overflow & ovf_chk; end
      S_EX_I: begin nxt = S_WB_I; ovf_nxt = overflow & ovf_chk; end
      S_MA:   nxt = (cls == C_LW) ? S_MR : S_MW;
      S_MR:   nxt = MIO_ready ? S_WB_L : S_MR;
      S_MW:   nxt = MIO_ready ? S_IF : S_MW;
      default: nxt = S_IF;
    endcase
  end

  // Control word is registered alongside the state so it always matches it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur      <= S_INIT;
      ovf_flag <= 1'b0;
      ctrl     <= ctrl_for(S_INIT, 1'b0, ALU_ADD);
    end else begin
      cur      <= nxt;
      ovf_flag <= ovf_nxt;
      ctrl     <= ctrl_for(nxt, ovf_nxt, dec_alu);
    end
  end

  assign pc_write     = ctrl.pc_write;
  assign pcwritecond  = ctrl.pcwritecond;
  assign branch       = ctrl.branch;
  assign IorD         = ctrl.iord;
  assign AluSrcA      = ctrl.alu_src_a;
  assign regwrite     = ctrl.regwrite;
  assign mem_w        = ctrl.mem_w;
  assign PCSource     = ctrl.pc_source;
  assign ALUSrcB      = ctrl.alu_src_b;
  assign RegDst       = ctrl.reg_dst;
  assign MemToReg     = ctrl.mem_to_reg;
  assign ALU_ops      = ctrl.alu_ops;
  assign IRwrite      = (cur == S_IF) & MIO_ready;
  assign illegal_inst = (cur == S_ID) & (cls == C_ILL);
  assign state        = ST_W'(cur);

endmodule

// File: doc/mcpu_ctrl.md
Name: mcpu_ctrl

Overview:
- Multicycle control unit that drives the multicycle CPU datapath.
- Sequences each MIPS instruction through fetch, decode, execute, memory and writeback states, and emits every datapath select and write-enable.
- Consumes `inst`, `zero`, `overflow` and `MIO_ready` from the datapath and memory/IO bus.
- Moore FSM: outputs decode from the current state only; sole exception is IRwrite in IF.

Parameters:
- ST_W, 5, state register width (exported on `state` for debug).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- inst  in  32  instruction register contents; opcode is [31:26], funct is [5:0].
- zero  in  1  ALU zero flag.
- overflow  in  1  ALU overflow flag.
- MIO_ready  in  1  memory/IO transfer complete.
- pc_write  out  1  unconditional PC write.
- pcwritecond  out  1  conditional PC write (branch).
- branch  out  1  1 = take when zero (beq); 0 = take when not zero (bne).
- IorD  out  1  memory address select; 0 = PC, 1 = ALU_out.
- AluSrcA  out  1  ALU A select; 0 = PC, 1 = rs.
- regwrite  out  1  register file write.
- IRwrite  out  1  instruction register load.
- mem_w  out  1  memory write strobe.
- PCSource  out  2  next-PC select; 00 = ALU, 01 = ALU_out, 10 = jump target.
- ALUSrcB  out  2  ALU B select; 00 = rt, 01 = 4, 10 = imm, 11 = imm<<2.
- RegDst  out  2  write register select; 00 = rt, 01 = rd, 10 = $31.
- MemToReg  out  2  write-back data select; 00 = ALU_out, 01 = MDR, 10 = {imm,16'b0}, 11 = PC.
- ALU_ops  out  3  ALU operation code (see package encodings).
- illegal_inst  out  1  one-cycle pulse on an unsupported instruction.
- state  out  ST_W  current state (debug).

Behaviour:
- Reset (asynchronous, while reset=0): state = INIT, ovf_flag = 0. Every output is 0 and ALU_ops = ADD. Reset mid-instruction aborts the instruction.
- INIT: always goes to IF on the next clock.
- IF: IorD=0, AluSrcA=0, ALUSrcB=01, ADD, PCSource=00, pc_write=1, IRwrite=MIO_ready. Stays in IF while MIO_ready=0; goes to ID when MIO_ready=1.
- ID: AluSrcA=0, ALUSrcB=11, ADD. This latches the branch target into ALU_out. Dispatch by opcode/funct:
  - R-type add/sub/and/or/xor/nor/slt → EX_R.
  - jr (funct 001000) → JR.
  - lw/sw → MA.
  - beq → BEQ; bne → BNE.
  - addi/andi/ori/slti → EX_I.
  - lui → LUI; j → J; jal → JAL.
  - Anything else → IF, with illegal_inst=1 for that cycle.
- EX_R: AluSrcA=1, ALUSrcB=00, ALU_ops from funct. ovf_flag <= overflow for add/sub, else 0. Next: WB_R.
- WB_R: RegDst=01, MemToReg=00, regwrite=~ovf_flag. Next: IF.
- EX_I: AluSrcA=1, ALUSrcB=10, ALU_ops from opcode. ovf_flag <= overflow for addi only. Next: WB_I.
- WB_I: RegDst=00, MemToReg=00, regwrite=~ovf_flag. Next: IF.
- Immediate extension: andi/ori use the sign-extended immediate. This is a documented limitation.
- MA: AluSrcA=1, ALUSrcB=10, ADD. Next: MR for lw, MW for sw.
- MR: IorD=1. Holds until MIO_ready=1, then goes to WB_L.
- WB_L: RegDst=00, MemToReg=01, regwrite=1. Next: IF.
- MW: IorD=1, mem_w=1. mem_w stays high while waiting for MIO_ready. Goes to IF when MIO_ready=1.
- BEQ/BNE: AluSrcA=1, ALUSrcB=00, SUB, pcwritecond=1, PCSource=01, branch = 1 (BEQ) or 0 (BNE). Next: IF.
- J: PCSource=10, pc_write=1. Next: IF.
- JAL: PCSource=10, pc_write=1, RegDst=10, MemToReg=11, regwrite=1 in the same cycle. $31 receives the pre-edge PC (already PC+4). Next: IF.
- JR: AluSrcA=1, ALUSrcB=00 (rt=$0 in the jr encoding), ADD, PCSource=00, pc_write=1. Next: IF.
- LUI: RegDst=00, MemToReg=10, regwrite=1. Next: IF.
- Defaults: any output not listed for a state is 0; ALU_ops defaults to ADD.
- Undefined state values recover to IF.
- Latency in cycles, including IF with zero wait states:
  - R-type and I-type ALU: 4.
  - lw: 5; sw: 4.
  - beq/bne/j/jal/jr/lui: 3.

Decomposition:
- Package mcpu_ctrl_pkg holds:
  - State encodings: INIT, IF, ID, EX_R, WB_R, EX_I, WB_I, MA, MR, WB_L, MW, BEQ, BNE, J, JAL, JR, LUI.
  - Opcode and funct constants.
  - ALU codes: AND=000, OR=001, ADD=010, XOR=011, NOR=100, SUB=110, SLT=111.
- One sub-module, mcpu_ctrl_dec: combinational opcode/funct → instruction class and ALU_ops. The FSM lives in mcpu_ctrl.

Test Plan:
- Reset: hold reset=0 mid-MR, release → state=INIT with all enables 0, then IF on the next edge.
- Fetch wait: MIO_ready=0 for 3 cycles in IF → IRwrite=0, state stays IF. MIO_ready=1 → IRwrite=1, then ID.
- add with overflow=1 in EX_R → WB_R regwrite=0. Same instruction with overflow=0 → regwrite=1, RegDst=01, ALU_ops=010.
- lw 0x8C220004 with MIO_ready delayed 2 cycles in MR → sequence MA, MR, MR, MR, WB_L. IorD=1 throughout MR; regwrite=1 and MemToReg=01 in WB_L.
- bne 0x14220003 → in BNE: pcwritecond=1, branch=0, ALU_ops=110, PCSource=01. jal 0x0C000010 → JAL: pc_write=1, regwrite=1, RegDst=10, MemToReg=11, PCSource=10.
- Opcode 0x3F → illegal_inst pulses 1 cycle at ID, next state IF, no write enables asserted.
